// File: rtl/arb_mux_2_if.sv
// Stream bundle for the two-source round-robin merge: two valid/ready inputs, one registered
// valid/ready output and the source index of the word on the output.
interface arb_mux_2_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] i0;
    logic             i0_valid;
    logic             i0_ready;
    logic [WIDTH-1:0] i1;
    logic             i1_valid;
    logic             i1_ready;
    logic [WIDTH-1:0] o;
    logic             o_valid;
    logic             o_ready;
    logic             sel;

    // Arbiter side
    modport slave (
        input  i0, i0_valid, i1, i1_valid, o_ready,
        output i0_ready, i1_ready, o, o_valid, sel
    );

    // Producer/consumer side
    modport master (
        output i0, i0_valid, i1, i1_valid, o_ready,
        input  i0_ready, i1_ready, o, o_valid, sel
    );
endinterface

// File: rtl/arb_mux_2.sv
// Two-input round-robin stream arbiter feeding a parameterized 2:1 mux. Each source lands in a
// one-entry slot; a registered output stage takes one slot per cycle while it is free.

// Parameterized 2:1 mux, purely combinational.
module mux_p_b #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? d1 : d0;
endmodule

module arb_mux_2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    arb_mux_2_if.slave  bus
);
    logic             full0_q, full1_q;
    logic [WIDTH-1:0] slot0_q, slot1_q;
    logic             last_q;
    logic [WIDTH-1:0] o_q;
    logic             o_valid_q;
    logic             sel_q;

    logic             out_free;
    logic             xfer;
    logic             grant;
    logic             acc0, acc1;
    logic [WIDTH-1:0] mux_y;

    // Grant decision: single full slot wins outright, contention goes to the one not served last.
    always_comb begin
        out_free = !o_valid_q || bus.o_ready;
        xfer     = out_free && (full0_q || full1_q);
        grant    = (full0_q && full1_q) ? !last_q : full1_q;
        acc0     = bus.i0_valid && !full0_q;
        acc1     = bus.i1_valid && !full1_q;
    end

    mux_p_b #(
        .WIDTH (WIDTH)
    ) u_mux (
        .d0  (slot0_q),
        .d1  (slot1_q),
        .sel (grant),
        .y   (mux_y)
    );

    // Slot 0: load on handshake, empty when granted (a slot is never loaded and granted at once).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full0_q <= 1'b0;
            slot0_q <= '0;
        end else if (acc0) begin
            full0_q <= 1'b1;
            slot0_q <= bus.i0;
        end else if (xfer && !grant) begin
            full0_q <= 1'b0;
        end
    end

    // Slot 1: same as slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full1_q <= 1'b0;
            slot1_q <= '0;
        end else if (acc1) begin
            full1_q <= 1'b1;
            slot1_q <= bus.i1;
        end else if (xfer && grant) begin
            full1_q <= 1'b0;
        end
    end

    // Output stage and round-robin memory; everything holds while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q       <= '0;
            o_valid_q <= 1'b0;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;  // first contention goes to source 0
        end else if (out_free) begin
            if (xfer) begin
                o_q       <= mux_y;
                sel_q     <= grant;
                o_valid_q <= 1'b1;
                last_q    <= grant;
            end else begin
                o_valid_q <= 1'b0;
            end
        end
    end

    assign bus.i0_ready = !full0_q;
    assign bus.i1_ready = !full1_q;
    assign bus.o        = o_q;
    assign bus.o_valid  = o_valid_q;
    assign bus.sel      = sel_q;
endmodule

// File: tb/tb_arb_mux_2.sv
// Directed bench for arb_mux_2: inputs change just after the falling edge, outputs are checked
// at the falling edge before new inputs are applied.
module tb_arb_mux_2;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    arb_mux_2_if #(.WIDTH(8)) bus ();

    arb_mux_2 #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        // Power-on reset values
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL por_o_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o !== 8'h00) begin errors++; $display("FAIL por_o got=%h exp=00", bus.o); end
        checks++; if ({bus.i0_ready, bus.i1_ready} !== 2'b11) begin errors++; $display("FAIL por_ready got=%b exp=11", {bus.i0_ready, bus.i1_ready}); end
        // Fill both slots with O_VALID=1 under backpressure
        bus.o_ready = 1'b0;
        bus.i0 = 8'h77; bus.i0_valid = 1'b1;
        bus.i1 = 8'h88; bus.i1_valid = 1'b1;
        tick();
        bus.i0_valid = 1'b0; bus.i1_valid = 1'b0;
        tick();
        bus.i0 = 8'h99; bus.i0_valid = 1'b1;
        tick();
        bus.i0_valid = 1'b0;
        checks++; if ({bus.o_valid, bus.o, bus.i0_ready, bus.i1_ready} !== {1'b1, 8'h77, 2'b00}) begin
            errors++; $display("FAIL rst_setup got=%b/%h/%b%b exp=1/77/00", bus.o_valid, bus.o, bus.i0_ready, bus.i1_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_o_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o !== 8'h00) begin errors++; $display("FAIL rst_o got=%h exp=00", bus.o); end
        checks++; if (bus.sel !== 1'b0) begin errors++; $display("FAIL rst_sel got=%b exp=0", bus.sel); end
        checks++; if ({bus.i0_ready, bus.i1_ready} !== 2'b11) begin errors++; $display("FAIL rst_ready got=%b exp=11", {bus.i0_ready, bus.i1_ready}); end
        tick();
        rst_n = 1'b1;
        bus.o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_stale cyc=%0d o_valid=%b exp=0", i, bus.o_valid); end
        end
    endtask

    task automatic test_single;
        bus.o_ready = 1'b1;
        bus.i0 = 8'h3C; bus.i0_valid = 1'b1;
        tick();
        bus.i0_valid = 1'b0;
        checks++; if (bus.i0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_low got=%b exp=0", bus.i0_ready); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", bus.o_valid); end
        tick();
        checks++; if ({bus.o_valid, bus.o, bus.sel} !== {1'b1, 8'h3C, 1'b0}) begin
            errors++; $display("FAIL single_out got=%b/%h/%b exp=1/3c/0", bus.o_valid, bus.o, bus.sel);
        end
        checks++; if (bus.i0_ready !== 1'b1) begin errors++; $display("FAIL single_ready_back got=%b exp=1", bus.i0_ready); end
        tick();
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle got=%b exp=0", bus.o_valid); end
    endtask

    task automatic test_contention;
        do_reset();
        bus.o_ready = 1'b1;
        bus.i0 = 8'hA1; bus.i0_valid = 1'b1;
        bus.i1 = 8'hB2; bus.i1_valid = 1'b1;
        tick();
        bus.i0_valid = 1'b0; bus.i1_valid = 1'b0;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL cont_early got=%b exp=0", bus.o_valid); end
        tick();
        checks++; if ({bus.o_valid, bus.o, bus.sel} !== {1'b1, 8'hA1, 1'b0}) begin
            errors++; $display("FAIL cont_first got=%b/%h/%b exp=1/a1/0", bus.o_valid, bus.o, bus.sel);
        end
        tick();
        checks++; if ({bus.o_valid, bus.o, bus.sel} !== {1'b1, 8'hB2, 1'b1}) begin
            errors++; $display("FAIL cont_second got=%b/%h/%b exp=1/b2/1", bus.o_valid, bus.o, bus.sel);
        end
        tick();
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL cont_idle got=%b exp=0", bus.o_valid); end
    endtask

    task automatic test_fairness;
        bus.o_ready = 1'b1;
        // I0 alone first so the I1 grant below must move LAST
        bus.i0 = 8'h10; bus.i0_valid = 1'b1;
        tick();
        bus.i0_valid = 1'b0;
        tick();
        checks++; if ({bus.o_valid, bus.o, bus.sel} !== {1'b1, 8'h10, 1'b0}) begin
            errors++; $display("FAIL fair_i0 got=%b/%h/%b exp=1/10/0", bus.o_valid, bus.o, bus.sel);
        end
        bus.i1 = 8'h11; bus.i1_valid = 1'b1;
        tick();
        bus.i1_valid = 1'b0;
        tick();
        checks++; if ({bus.o_valid, bus.o, bus.sel} !== {1'b1, 8'h11, 1'b1}) begin
            errors++; $display("FAIL fair_i1 got=%b/%h/%b exp=1/11/1", bus.o_valid, bus.o, bus.sel);
        end
        bus.i0 = 8'h20; bus.i0_valid = 1'b1;
        bus.i1 = 8'h21; bus.i1_valid = 1'b1;
        tick();
        bus.i0_valid = 1'b0; bus.i1_valid = 1'b0;
        tick();
        checks++; if ({bus.o_valid, bus.o, bus.sel} !== {1'b1, 8'h20, 1'b0}) begin
            errors++; $display("FAIL fair_first got=%b/%h/%b exp=1/20/0", bus.o_valid, bus.o, bus.sel);
        end
        tick();
        checks++; if ({bus.o_valid, bus.o, bus.sel} !== {1'b1, 8'h21, 1'b1}) begin
            errors++; $display("FAIL fair_second got=%b/%h/%b exp=1/21/1", bus.o_valid, bus.o, bus.sel);
        end
        tick();
    endtask

    task automatic test_backpressure;
        do_reset();
        bus.o_ready = 1'b0;
        bus.i0 = 8'h55; bus.i0_valid = 1'b1;
        bus.i1 = 8'h66; bus.i1_valid = 1'b1;
        tick();
        bus.i0_valid = 1'b0; bus.i1_valid = 1'b0;
        tick();
        bus.i0 = 8'h77; bus.i0_valid = 1'b1;
        tick();
        bus.i0_valid = 1'b0;
        // O=55 from source 0, slot0=77, slot1=66, stalled
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.o_valid, bus.o, bus.sel, bus.i0_ready, bus.i1_ready} !== {1'b1, 8'h55, 1'b0, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got=%b/%h/%b/%b%b exp=1/55/0/00", i, bus.o_valid, bus.o,
                         bus.sel, bus.i0_ready, bus.i1_ready);
            end
            tick();
        end
        bus.o_ready = 1'b1;
        tick();
        checks++; if ({bus.o_valid, bus.o, bus.sel} !== {1'b1, 8'h66, 1'b1}) begin
            errors++; $display("FAIL bp_drain1 got=%b/%h/%b exp=1/66/1", bus.o_valid, bus.o, bus.sel);
        end
        tick();
        checks++; if ({bus.o_valid, bus.o, bus.sel} !== {1'b1, 8'h77, 1'b0}) begin
            errors++; $display("FAIL bp_drain2 got=%b/%h/%b exp=1/77/0", bus.o_valid, bus.o, bus.sel);
        end
        tick();
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL bp_no_repeat got=%b exp=0", bus.o_valid); end
    endtask

    task automatic test_streams;
        int       idx0, idx1, n, cyc;
        logic     hs0, hs1;
        logic [7:0] exp_o;
        logic       exp_sel;
        do_reset();
        bus.o_ready = 1'b1;
        idx0 = 0; idx1 = 0; n = 0; cyc = 0;
        hs0 = 1'b0; hs1 = 1'b0;
        while (n < 32 && cyc < 200) begin
            if (bus.o_valid === 1'b1) begin
                exp_sel = n[0];
                exp_o   = exp_sel ? (8'h80 + 8'(n / 2)) : 8'(n / 2);
                checks++;
                if ({bus.o, bus.sel} !== {exp_o, exp_sel}) begin
                    errors++;
                    $display("FAIL stream word=%0d got=%h/%b exp=%h/%b", n, bus.o, bus.sel, exp_o, exp_sel);
                end
                n++;
            end
            if (hs0) idx0++;
            if (hs1) idx1++;
            bus.i0_valid = (idx0 < 16);
            bus.i0       = 8'(idx0);
            bus.i1_valid = (idx1 < 16);
            bus.i1       = 8'h80 + 8'(idx1);
            hs0 = bus.i0_valid && bus.i0_ready;
            hs1 = bus.i1_valid && bus.i1_ready;
            tick();
            cyc++;
        end
        bus.i0_valid = 1'b0; bus.i1_valid = 1'b0;
        checks++; if (n !== 32) begin errors++; $display("FAIL stream_count got=%0d exp=32", n); end
        // 32 words plus 2 cycles of pipeline fill
        checks++; if (cyc !== 34) begin errors++; $display("FAIL stream_rate cycles=%0d exp=34", cyc); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL stream_extra got=%b exp=0", bus.o_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.i0 = '0; bus.i0_valid = 1'b0;
        bus.i1 = '0; bus.i1_valid = 1'b0;
        bus.o_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_streams();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
